// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator.
// A clock divider produces the pixel strobe; horizontal and vertical counters
// advance on that strobe. Every output is registered and updated on the same
// edge as the counters, so downstream address generators see clean values.
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pclk_en,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic       SYNC_ON      = 1'(SYNC_POL);
   localparam logic       SYNC_OFF     = ~SYNC_ON;

   typedef enum logic [1:0] {
      H_ACT   = 2'd0,
      H_FRONT = 2'd1,
      H_SYN   = 2'd2,
      H_BACK  = 2'd3
   } h_state_t;

   logic [3:0] div_cnt_r;
   logic       tick_s;
   logic [9:0] h_nxt_s;
   logic [9:0] v_nxt_s;
   logic       h_zero_s;
   logic       frame_zero_s;
   h_state_t   h_state_r;
   h_state_t   h_state_nxt_s;

   // The last divider phase is the edge on which a new pixel begins.
   assign tick_s = (div_cnt_r == DIV_LAST);

   // Pixel-clock divider: free-running count 0..CLK_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r <= 4'd0;
      end else if (tick_s) begin
         div_cnt_r <= 4'd0;
      end else begin
         div_cnt_r <= div_cnt_r + 4'd1;
      end
   end

   // Counter values the raster moves to on the next pixel strobe.
   always_comb begin
      h_nxt_s = h_cnt;
      v_nxt_s = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt_s = 10'd0;
         if (v_cnt == V_LAST) begin
            v_nxt_s = 10'd0;
         end else begin
            v_nxt_s = v_cnt + 10'd1;
         end
      end else begin
         h_nxt_s = h_cnt + 10'd1;
         v_nxt_s = v_cnt;
      end
   end

   assign h_zero_s     = (h_nxt_s == 10'd0);
   assign frame_zero_s = h_zero_s && (v_nxt_s == 10'd0);

   // Horizontal region next-state, keyed on the position being entered.
   always_comb begin
      h_state_nxt_s = h_state_r;
      case (h_state_r)
         H_ACT: begin
            if (h_nxt_s == H_FP_START) h_state_nxt_s = H_FRONT;
            else                       h_state_nxt_s = H_ACT;
         end
         H_FRONT: begin
            if (h_nxt_s == H_SYNC_START) h_state_nxt_s = H_SYN;
            else                         h_state_nxt_s = H_FRONT;
         end
         H_SYN: begin
            if (h_nxt_s == H_BP_START) h_state_nxt_s = H_BACK;
            else                       h_state_nxt_s = H_SYN;
         end
         H_BACK: begin
            if (h_zero_s) h_state_nxt_s = H_ACT;
            else          h_state_nxt_s = H_BACK;
         end
         default: h_state_nxt_s = H_BACK;
      endcase
   end

   // Horizontal region register, advancing only on the pixel strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_state_r <= H_BACK;
      end else if (tick_s) begin
         h_state_r <= h_state_nxt_s;
      end else begin
         h_state_r <= h_state_r;
      end
   end

   // Counters and all decoded outputs, registered together on the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pclk_en     <= 1'b0;
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         valid       <= 1'b0;
         hsync       <= SYNC_OFF;
         vsync       <= SYNC_OFF;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         pclk_en <= tick_s;
         if (tick_s) begin
            h_cnt       <= h_nxt_s;
            v_cnt       <= v_nxt_s;
            valid       <= (h_nxt_s < H_FP_START) && (v_nxt_s < V_ACT_END);
            hsync       <= (h_state_nxt_s == H_SYN) ? SYNC_ON : SYNC_OFF;
            vsync       <= ((v_nxt_s >= V_SYNC_START) && (v_nxt_s < V_SYNC_END))
                           ? SYNC_ON : SYNC_OFF;
            line_start  <= h_zero_s;
            frame_start <= frame_zero_s;
            if (frame_zero_s) begin
               frame_cnt <= frame_cnt + 8'd1;
            end else begin
               frame_cnt <= frame_cnt;
            end
         end else begin
            h_cnt       <= h_cnt;
            v_cnt       <= v_cnt;
            valid       <= valid;
            hsync       <= hsync;
            vsync       <= vsync;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= frame_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full 640x480, a tiny raster for
// frame-counter wrap, and an active-high / fast-divider variant) each checked
// every clock against an arithmetic raster model, plus literal spot checks.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_bc = 1'b1;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A: default parameters.
   logic       a_pe, a_valid, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_h, a_v;
   logic [7:0] a_fc;
   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a), .pclk_en(a_pe), .h_cnt(a_h), .v_cnt(a_v),
      .valid(a_valid), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
      .frame_start(a_fs), .frame_cnt(a_fc));

   // Instance B: tiny raster (10 x 7) so 256 frames fit in a short run.
   logic       b_pe, b_valid, b_hs, b_vs, b_ls, b_fs;
   logic [9:0] b_h, b_v;
   logic [7:0] b_fc;
   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_b (
      .clk(clk), .rst(rst_bc), .pclk_en(b_pe), .h_cnt(b_h), .v_cnt(b_v),
      .valid(b_valid), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
      .frame_start(b_fs), .frame_cnt(b_fc));

   // Instance C: active-high syncs, pixel every 2 clocks, full-width lines.
   logic       c_pe, c_valid, c_hs, c_vs, c_ls, c_fs;
   logic [9:0] c_h, c_v;
   logic [7:0] c_fc;
   vga_timing_gen #(.CLK_DIV(2), .SYNC_POL(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_c (
      .clk(clk), .rst(rst_bc), .pclk_en(c_pe), .h_cnt(c_h), .v_cnt(c_v),
      .valid(c_valid), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls),
      .frame_start(c_fs), .frame_cnt(c_fc));

   // Clock edges seen since each reset was last released.
   longint ka = 0;
   longint kb = 0;
   always @(posedge clk or posedge rst_a) begin
      if (rst_a) ka <= 0;
      else       ka <= ka + 1;
   end
   always @(posedge clk or posedge rst_bc) begin
      if (rst_bc) kb <= 0;
      else        kb <= kb + 1;
   end

   // Raster model: after k edges the pixel index is k/div - 1; position,
   // syncs, pulses and frame count follow directly by division and modulo.
   function automatic logic [33:0] model(longint k, int div,
         int ha, int hfp, int hs, int hbp, int va, int vfp, int vs, int vbp, int pol);
      int ht, vt, h, v, fc;
      longint p;
      logic pe, on, off, hsy, vsy, vl, ls, fs;
      ht  = ha + hfp + hs + hbp;
      vt  = va + vfp + vs + vbp;
      on  = (pol != 0);
      off = !on;
      if (k < div) begin
         h = ht - 1; v = vt - 1; fc = 0; pe = 1'b0;
      end else begin
         p  = k / div - 1;
         h  = int'(p % ht);
         v  = int'((p / ht) % vt);
         fc = int'(((p / (ht * vt)) + 1) % 256);
         pe = (k % div == 0);
      end
      vl  = (h < ha) && (v < va);
      hsy = (h >= ha + hfp && h < ha + hfp + hs) ? on : off;
      vsy = (v >= va + vfp && v < va + vfp + vs) ? on : off;
      ls  = pe && (h == 0);
      fs  = ls && (v == 0);
      return {pe, 10'(h), 10'(v), vl, hsy, vsy, ls, fs, 8'(fc)};
   endfunction

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all three instances against the model.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("a_model", {a_pe, a_h, a_v, a_valid, a_hs, a_vs, a_ls, a_fs, a_fc},
             model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0));
         chk("b_model", {b_pe, b_h, b_v, b_valid, b_hs, b_vs, b_ls, b_fs, b_fc},
             model(kb, 2, 4, 2, 2, 2, 4, 1, 1, 1, 0));
         chk("c_model", {c_pe, c_h, c_v, c_valid, c_hs, c_vs, c_ls, c_fs, c_fc},
             model(kb, 2, 640, 16, 96, 48, 4, 1, 1, 1, 1));
      end
   end

   // Directed sequence with hand-computed literal expectations.
   initial begin
      repeat (3) @(negedge clk);
      chk("a_reset_state", {a_pe, a_h, a_v, a_valid, a_hs, a_vs, a_ls, a_fs, a_fc},
          {1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      rst_a  = 1'b0;
      rst_bc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("c_first_pixel", {c_pe, c_h, c_v, c_fs, c_ls, c_fc},
          {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 8'd1});
      @(negedge clk);
      chk("a_before_first", {a_pe, a_h, a_v}, {1'b0, 10'd799, 10'd524});
      @(negedge clk);
      chk("a_first_pixel", {a_pe, a_h, a_v, a_valid, a_ls, a_fs, a_fc},
          {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd1});
      @(negedge clk);
      chk("a_strobe_one_clk", {a_pe, a_h, a_ls, a_fs}, {1'b0, 10'd0, 1'b0, 1'b0});

      for (int i = 0; i < 4000; i++) begin
         if (c_h == 10'd656) break;
         @(negedge clk);
      end
      chk("c_hsync_active_high", {c_h, c_hs}, {10'd656, 1'b1});

      for (int i = 0; i < 4000; i++) begin
         if (a_h == 10'd639) break;
         @(negedge clk);
      end
      chk("a_last_visible", {a_h, a_valid, a_hs}, {10'd639, 1'b1, 1'b1});

      for (int i = 0; i < 4000; i++) begin
         if (a_h == 10'd656) break;
         @(negedge clk);
      end
      chk("a_hsync_start", {a_h, a_valid, a_hs}, {10'd656, 1'b0, 1'b0});

      for (int i = 0; i < 4000; i++) begin
         if (a_h == 10'd752) break;
         @(negedge clk);
      end
      chk("a_hsync_end", {a_h, a_hs}, {10'd752, 1'b1});

      for (int i = 0; i < 8000; i++) begin
         if (a_v == 10'd1 && a_h == 10'd300) break;
         @(negedge clk);
      end
      chk("a_reach_mid_line", {a_v, a_h}, {10'd1, 10'd300});
      #1 rst_a = 1'b1;
      #1;
      chk("a_mid_reset", {a_pe, a_h, a_v, a_valid, a_hs, a_vs, a_ls, a_fs, a_fc},
          {1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      repeat (4) @(negedge clk);
      chk("a_restart", {a_pe, a_h, a_v, a_fs, a_ls, a_fc},
          {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 8'd1});

      for (int i = 0; i < 60000; i++) begin
         if (b_fs && b_fc == 8'd0) break;
         @(negedge clk);
      end
      chk("b_frame_cnt_wrap", {b_fs, b_h, b_v, b_fc}, {1'b1, 10'd0, 10'd0, 8'd0});
      @(negedge clk);
      @(negedge clk);
      chk("b_after_wrap", {b_h, b_v, b_fc}, {10'd1, 10'd0, 8'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
